// File: rtl/multi_button_debouncer_pkg.sv
// Shared timing constants, repeat-FSM encoding and counter-sizing helpers
// for the multi-channel push-button debouncer.
package multi_button_debouncer_pkg;

  localparam int DB_10MS_AT_50MHZ    = 500000;
  localparam int DB_SIM_FAST         = 4;
  localparam int DB_REPEAT_DELAY_DEF = 25000000;
  localparam int DB_REPEAT_RATE_DEF  = 5000000;

  typedef enum logic [1:0] {
    RP_IDLE  = 2'd0,
    RP_DELAY = 2'd1,
    RP_RATE  = 2'd2,
    RP_DONE  = 2'd3
  } rp_state_e;

  function automatic int db_clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int db_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multi_button_debouncer_if.sv
// Button bundle between raw pins and the debug controller: pins in,
// debounced level and one-cycle event pulses out.
interface multi_button_debouncer_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_state;
  logic [N_CH-1:0] btn_rise;
  logic [N_CH-1:0] btn_fall;
  logic [N_CH-1:0] btn_repeat;
  logic            any_rise;

  modport master (
    output btn_in,
    input  btn_state, btn_rise, btn_fall, btn_repeat, any_rise
  );

  modport slave (
    input  btn_in,
    output btn_state, btn_rise, btn_fall, btn_repeat, any_rise
  );
endinterface

// File: rtl/multi_button_debouncer_channel.sv
// One button channel: 2-FF synchroniser, stable-time filter, edge pulses
// and hold-to-auto-repeat sequencer.
module debounce_channel
  import multi_button_debouncer_pkg::*;
#(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int STABLE_CYCLES = 65536,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_RATE   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_state,
  output logic o_rise,
  output logic o_fall,
  output logic o_repeat,
  output logic o_rise_nxt
);

  localparam int CW  = db_clog2(STABLE_CYCLES);
  localparam int HCW = db_max(db_clog2(db_max(REPEAT_DELAY, REPEAT_RATE) + 1), 1);

  localparam logic [CW-1:0]  CNT_TERM  = CW'(STABLE_CYCLES - 1);
  localparam logic [HCW-1:0] DLY_TERM  = HCW'(db_max(REPEAT_DELAY, 1) - 1);
  localparam logic [HCW-1:0] RATE_TERM = HCW'(db_max(REPEAT_RATE, 1) - 1);
  localparam bit             RP_EN     = (REPEAT_DELAY > 0);
  localparam bit             RATE_EN   = (REPEAT_RATE > 0);

  logic            r_sync_p0;
  logic            r_sync_p1;
  logic [CW-1:0]   r_cnt;
  logic            r_state;
  logic            r_rise;
  logic            r_fall;
  logic            w_differ;
  logic            w_toggle;

  rp_state_e       r_rp_state;
  rp_state_e       w_rp_next;
  logic [HCW-1:0]  r_hc;
  logic [HCW-1:0]  w_hc_next;
  logic            r_repeat;
  logic            w_repeat_next;
  logic            w_held;

  // Stage p0/p1: synchroniser, polarity folded in so 1 always means pressed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= i_btn ^ ACTIVE_LOW;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_differ = (r_sync_p1 != r_state);
  assign w_toggle = w_differ && (r_cnt == CNT_TERM);

  // Filter stage: any sample agreeing with the current level restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_toggle) begin
        r_cnt   <= '0;
        r_state <= ~r_state;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_rise <= w_toggle & ~r_state;
      r_fall <= w_toggle &  r_state;
    end
  end

  // The toggle edge itself does not count as held, so a repeat can never
  // land in the rise or fall cycle.
  assign w_held = RP_EN && r_state && !w_toggle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rp_state <= RP_IDLE;
      r_hc       <= '0;
      r_repeat   <= 1'b0;
    end else begin
      r_rp_state <= w_rp_next;
      r_hc       <= w_hc_next;
      r_repeat   <= w_repeat_next;
    end
  end

  always_comb begin
    w_rp_next     = r_rp_state;
    w_hc_next     = r_hc;
    w_repeat_next = 1'b0;
    if (!w_held) begin
      w_rp_next = RP_IDLE;
      w_hc_next = '0;
    end else begin
      case (r_rp_state)
        RP_IDLE, RP_DELAY: begin
          if (r_hc == DLY_TERM) begin
            w_repeat_next = 1'b1;
            w_hc_next     = '0;
            w_rp_next     = RATE_EN ? RP_RATE : RP_DONE;
          end else begin
            w_hc_next = r_hc + 1'b1;
            w_rp_next = RP_DELAY;
          end
        end
        RP_RATE: begin
          if (r_hc == RATE_TERM) begin
            w_repeat_next = 1'b1;
            w_hc_next     = '0;
          end else begin
            w_hc_next = r_hc + 1'b1;
          end
        end
        RP_DONE: begin
          // single repeat already issued; park here until release
          w_hc_next = r_hc;
        end
        default: begin
          w_rp_next = RP_IDLE;
          w_hc_next = '0;
        end
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_repeat   = r_repeat;
  assign o_rise_nxt = w_toggle & ~r_state;

endmodule

// File: rtl/multi_button_debouncer.sv
// N independent debounce channels plus a registered any-press strobe
// aligned with the per-channel rise pulses.
module multi_button_debouncer
  import multi_button_debouncer_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int STABLE_CYCLES = 65536,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_RATE   = 0
) (
  input logic                    clk,
  input logic                    rst,
  multi_button_debouncer_if.slave io_bus
);

  logic [N_CH-1:0] w_state;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;
  logic [N_CH-1:0] w_repeat;
  logic [N_CH-1:0] w_rise_nxt;
  logic            r_any_rise;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_btn     (io_bus.btn_in[g]),
      .o_state   (w_state[g]),
      .o_rise    (w_rise[g]),
      .o_fall    (w_fall[g]),
      .o_repeat  (w_repeat[g]),
      .o_rise_nxt(w_rise_nxt[g])
    );
  end

  // Built from the pre-register rise terms so it lands in the same cycle as btn_rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_any_rise <= 1'b0;
    else     r_any_rise <= |w_rise_nxt;
  end

  assign io_bus.btn_state  = w_state;
  assign io_bus.btn_rise   = w_rise;
  assign io_bus.btn_fall   = w_fall;
  assign io_bus.btn_repeat = w_repeat;
  assign io_bus.any_rise   = r_any_rise;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Randomised and directed bench for multi_button_debouncer against a
// sample-window / press-age reference model.
module tb_multi_button_debouncer;

  localparam int N_CH = 2;
  localparam int SC   = 4;
  localparam int RD   = 8;
  localparam int RR   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_button_debouncer_if #(.N_CH(N_CH)) bus ();
  multi_button_debouncer_if #(.N_CH(N_CH)) bus_nr ();
  assign bus_nr.btn_in = bus.btn_in;

  multi_button_debouncer #(
    .N_CH(N_CH), .ACTIVE_LOW(1'b1), .STABLE_CYCLES(SC),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .io_bus(bus)
  );

  multi_button_debouncer #(
    .N_CH(N_CH), .ACTIVE_LOW(1'b1), .STABLE_CYCLES(SC),
    .REPEAT_DELAY(0), .REPEAT_RATE(0)
  ) dut_nr (
    .clk(clk), .rst(rst), .io_bus(bus_nr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: pressed samples per edge, newest in bit 0
  bit [15:0]       m_hist [N_CH];
  bit [N_CH-1:0]   m_state, m_rise, m_fall, m_rep;
  bit              m_any;
  int              m_age  [N_CH];

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_hist[c] = '0;
      m_age[c]  = 0;
    end
    m_state = '0; m_rise = '0; m_fall = '0; m_rep = '0; m_any = 1'b0;
  endtask

  task automatic model_edge();
    bit all_diff;
    for (int c = 0; c < N_CH; c++) begin
      m_hist[c] = {m_hist[c][14:0], ~bus.btn_in[c]};
      all_diff = 1'b1;
      // the filter at this edge sees the samples taken 2..SC+1 edges ago
      for (int j = 2; j < SC + 2; j++)
        if (m_hist[c][j] == m_state[c]) all_diff = 1'b0;
      m_rise[c] = all_diff && !m_state[c];
      m_fall[c] = all_diff &&  m_state[c];
      if (all_diff) m_state[c] = ~m_state[c];
      if (all_diff || !m_state[c]) m_age[c] = 0;
      else                         m_age[c]++;
      m_rep[c] = !all_diff && m_state[c] && (m_age[c] >= RD) && (((m_age[c] - RD) % RR) == 0);
    end
    m_any = |m_rise;
  endtask

  task automatic compare_all();
    chk("state",    bus.btn_state,     m_state);
    chk("rise",     bus.btn_rise,      m_rise);
    chk("fall",     bus.btn_fall,      m_fall);
    chk("repeat",   bus.btn_repeat,    m_rep);
    chk("any_rise", bus.any_rise,      m_any);
    chk("nr_state", bus_nr.btn_state,  m_state);
    chk("nr_rise",  bus_nr.btn_rise,   m_rise);
    chk("nr_rep",   bus_nr.btn_repeat, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Asynchronous assert between edges, release 1 time unit after an edge
  task automatic do_reset(input int n_edges);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_state", {bus.btn_state, bus.btn_rise, bus.btn_fall}, '0);
    chk("rst_async_misc",  {bus.btn_repeat, bus.any_rise}, '0);
    model_reset();
    repeat (n_edges) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int rem [N_CH];
  int n_rep;

  initial begin
    rst        = 1'b1;
    bus.btn_in = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", {bus.btn_state, bus.btn_rise, bus.btn_fall, bus.btn_repeat, bus.any_rise}, '0);
    repeat (3) tick();

    // press ch0: level and rise appear at edge SC+1
    bus.btn_in[0] = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 4) chk("t1_state_early", bus.btn_state[0], 1'b0);
      if (e == 5) begin
        chk("t1_state", bus.btn_state[0], 1'b1);
        chk("t1_rise",  bus.btn_rise[0],  1'b1);
        chk("t1_any",   bus.any_rise,     1'b1);
      end
      if (e == 6) chk("t1_rise_one_cycle", bus.btn_rise[0], 1'b0);
    end
    bus.btn_in[0] = 1'b1;
    repeat (10) tick();

    // glitch shorter than the stable time
    bus.btn_in[0] = 1'b0;
    repeat (3) tick();
    bus.btn_in[0] = 1'b1;
    repeat (10) tick();
    chk("t2_glitch_state", bus.btn_state[0], 1'b0);

    // hold with auto-repeat, then release
    n_rep = 0;
    bus.btn_in[0] = 1'b0;
    for (int e = 0; e <= 30; e++) begin
      tick();
      if (bus.btn_repeat[0]) n_rep++;
      if (e == 13) chk("t3_first_repeat", bus.btn_repeat[0], 1'b1);
      if (e == 17) chk("t3_rate_repeat",  bus.btn_repeat[0], 1'b1);
    end
    chk("t3_repeat_count", n_rep, 5);
    bus.btn_in[0] = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      tick();
      if (e == 5) chk("t3_fall", bus.btn_fall[0], 1'b1);
      if (e >= 5) chk("t3_no_rep_after_fall", bus.btn_repeat[0], 1'b0);
    end

    // simultaneous press on both channels
    bus.btn_in = '0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) begin
        chk("t4_rise_both", bus.btn_rise, 2'b11);
        chk("t4_any",       bus.any_rise, 1'b1);
      end
      if (e == 6) chk("t4_any_one_cycle", bus.any_rise, 1'b0);
    end
    bus.btn_in = '1;
    repeat (10) tick();

    // reset mid-count while ch1 is already pressed, pin held through release
    bus.btn_in[1] = 1'b0;
    repeat (8) tick();
    chk("t5_ch1_pressed", bus.btn_state[1], 1'b1);
    bus.btn_in[0] = 1'b0;
    repeat (4) tick();
    do_reset(2);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == SC + 1) chk("t5_state_early", bus.btn_state, 2'b00);
      if (e == SC + 2) begin
        chk("t5_state", bus.btn_state, 2'b11);
        chk("t5_rise",  bus.btn_rise,  2'b11);
      end
    end
    bus.btn_in = '1;
    repeat (10) tick();

    // randomised segments: mix of glitches and long holds
    for (int c = 0; c < N_CH; c++) rem[c] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          bus.btn_in[c] = ~bus.btn_in[c];
          rem[c] = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, SC)) : int'($urandom_range(SC + 1, 40));
        end
      end
      if (i == 1500) do_reset($urandom_range(1, 3));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
